// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_seq_state_t;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned LOSS_W = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, async active-low reset.
module cdc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: qualifies PLL lock, releases staged resets, counts lock losses.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned STAGE_GAP   = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              lock_i,
  output logic [STAGES-1:0] rst_n_o,
  output logic              ready_o,
  output logic [7:0]        loss_cnt_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_seq: SYNC_STAGES must be >= 2");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("rst_seq: LOCK_CYCLES must be >= 1");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("rst_seq: STAGES must be in 1..8");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("rst_seq: STAGE_GAP must be >= 1");
  end

  localparam int unsigned CNT_MAX = max_u(LOCK_CYCLES, STAGE_GAP);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic                w_lock_s;
  rst_seq_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [STAGES-1:0]   r_rst_n, w_rst_n_nxt;
  logic                r_ready, w_ready_nxt;
  logic [LOSS_W-1:0]   r_loss_cnt, w_loss_nxt;

  cdc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (lock_i),
    .q_o     (w_lock_s)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rst_n    <= '0;
      r_ready    <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_rst_n    <= w_rst_n_nxt;
      r_ready    <= w_ready_nxt;
      r_loss_cnt <= w_loss_nxt;
    end
  end

  // Lock drop in RELEASE/RUN wins over any same-cycle release or count completion.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_n_nxt = r_rst_n;
    w_ready_nxt = r_ready;
    w_loss_nxt  = r_loss_cnt;

    case (r_state)
      WAIT_LOCK: begin
        w_rst_n_nxt = '0;
        w_ready_nxt = 1'b0;
        w_cnt_nxt   = '0;
        if (w_lock_s) begin
          w_state_nxt = STABLE;
        end
      end

      STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_rst_n_nxt = STAGES'(1);
          if (STAGES == 1) begin
            w_state_nxt = RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = RELEASE;
            w_idx_nxt   = IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          w_loss_nxt  = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;
        end else if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
          w_cnt_nxt   = '0;
          w_rst_n_nxt = r_rst_n | (STAGES'(1) << r_idx);
          if (r_idx == IDX_W'(STAGES - 1)) begin
            w_state_nxt = RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          w_loss_nxt  = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_rst_n_nxt = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  assign rst_n_o    = r_rst_n;
  assign ready_o    = r_ready;
  assign loss_cnt_o = r_loss_cnt;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with SYNC_STAGES=2, LOCK_CYCLES=8, STAGES=3, STAGE_GAP=4.
module tb_rst_seq;

  logic       clk_i;
  logic       rst_n_i;
  logic       lock_i;
  logic [2:0] rst_n_o;
  logic       ready_o;
  logic [7:0] loss_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  rst_seq #(
    .SYNC_STAGES (2),
    .LOCK_CYCLES (8),
    .STAGES      (3),
    .STAGE_GAP   (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .lock_i     (lock_i),
    .rst_n_o    (rst_n_o),
    .ready_o    (ready_o),
    .loss_cnt_o (loss_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int unsigned e_rst,
                         input int unsigned e_rdy, input int unsigned e_loss);
    chk({tag, ".rst_n"}, int'(rst_n_o), e_rst);
    chk({tag, ".ready"}, int'(ready_o), e_rdy);
    chk({tag, ".loss"},  int'(loss_cnt_o), e_loss);
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Lock goes high from the next edge N: stage 0 at N+10, stage 1 at N+14, stage 2 at N+18.
  task automatic lock_to_run(input string tag, input int unsigned e_loss);
    lock_i = 1'b1;
    edges(10); chk_out({tag, ".pre"}, 0, 0, e_loss);
    edges(1);  chk_out({tag, ".s0"},  1, 0, e_loss);
    edges(3);  chk_out({tag, ".s0h"}, 1, 0, e_loss);
    edges(1);  chk_out({tag, ".s1"},  3, 0, e_loss);
    edges(3);  chk_out({tag, ".s1h"}, 3, 0, e_loss);
    edges(1);  chk_out({tag, ".s2"},  7, 1, e_loss);
  endtask

  // Drop lock from the next edge M; everything falls at M+2.
  task automatic drop_lock(input string tag, input int unsigned e_rst,
                           input int unsigned e_rdy, input int unsigned e_loss);
    lock_i = 1'b0;
    edges(2); chk_out({tag, ".hold"}, e_rst, e_rdy, e_loss - 1);
    edges(1); chk_out({tag, ".drop"}, 0, 0, e_loss);
  endtask

  initial begin
    rst_n_i = 1'b0;
    lock_i  = 1'b0;
    edges(3);
    chk_out("reset", 0, 0, 0);
    rst_n_i = 1'b1;
    edges(2);
    chk_out("idle", 0, 0, 0);

    lock_to_run("clean", 0);
    edges(5);
    chk_out("run_hold", 7, 1, 0);

    // Asynchronous reset in RUN clears everything before the next edge.
    #3 rst_n_i = 1'b0;
    lock_i = 1'b0;
    #1 chk_out("arst_run", 0, 0, 0);
    #2 rst_n_i = 1'b1;
    edges(3);

    // Unstable lock: 5 high, 1 low, then high again restarts qualification.
    lock_i = 1'b1;
    edges(5);
    lock_i = 1'b0;
    edges(1);
    chk_out("unst.mid", 0, 0, 0);
    lock_to_run("unst", 0);

    // Loss in RUN, then re-lock repeats full qualification.
    edges(4);
    drop_lock("loss_run", 7, 1, 1);
    edges(2);
    lock_to_run("relock", 1);

    // Loss mid-RELEASE on the cycle stage 1 would rise.
    drop_lock("loss_run2", 7, 1, 2);
    lock_i = 1'b1;
    edges(11);
    chk_out("mid.s0", 1, 0, 2);
    edges(1);
    lock_i = 1'b0;
    edges(2);
    chk_out("mid.hold", 1, 0, 2);
    edges(1);
    chk_out("mid.drop", 0, 0, 3);

    // Asynchronous reset mid-RELEASE, then restart from WAIT_LOCK.
    edges(2);
    lock_i = 1'b1;
    edges(12);
    chk_out("arst.pre", 1, 0, 3);
    #3 rst_n_i = 1'b0;
    #1 chk_out("arst_rel", 0, 0, 0);
    #2 rst_n_i = 1'b1;
    edges(10);
    chk_out("arst.wait", 0, 0, 0);
    edges(1);
    chk_out("arst.s0", 1, 0, 0);

    // Saturation: 260 loss events from a zeroed counter.
    lock_i = 1'b0;
    edges(3);
    chk_out("sat.start", 0, 0, 1);
    for (int i = 2; i <= 260; i++) begin
      lock_i = 1'b1;
      edges(11);
      lock_i = 1'b0;
      edges(3);
      if (i == 254) chk("sat.254", int'(loss_cnt_o), 254);
      if (i == 255) chk("sat.255", int'(loss_cnt_o), 255);
    end
    chk_out("sat.end", 0, 0, 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer consuming a PLL's lock indication in the PLL output clock domain. Synchronizes the asynchronous lock input and qualifies it for a programmable stable period. It then releases a set of downstream active-low resets one stage at a time, with a fixed gap between stages. On lock loss it re-asserts all resets and counts the event. It sits directly after the PLL wrapper; its outputs replace raw lock as the design's reset tree root.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for lock_i (≥2)
- LOCK_CYCLES, 1024, consecutive synced-lock-high cycles required before release (≥1)
- STAGES, 3, number of staged reset outputs (1..8)
- STAGE_GAP, 16, cycles between successive stage releases (≥1)

Ports:
- clk_i  in  1  PLL output clock; sole clock
- rst_n_i  in  1  asynchronous, active-low reset
- lock_i  in  1  PLL lock, asynchronous to clk_i
- rst_n_o  out  STAGES  staged active-low resets; bit 0 released first
- ready_o  out  1  high when all stages are released (state RUN)
- loss_cnt_o  out  8  lock-loss events, saturating

## Operation
- Reset: rst_n_i low asynchronously clears the sync chain, rst_n_o=0, ready_o=0, loss_cnt_o=0, state WAIT_LOCK, counter 0.
- lock_s = output of the SYNC_STAGES-deep flop chain on lock_i.
- FSM states:
  - WAIT_LOCK: all outputs low. lock_s=1 → STABLE, cnt=0.
  - STABLE: lock_s=0 → WAIT_LOCK, no loss count. cnt==LOCK_CYCLES-1 → RELEASE, cnt=0, rst_n_o[0]=1. Otherwise cnt+1.
  - RELEASE: stage index k starts at 1. When cnt==STAGE_GAP-1: rst_n_o[k]=1, cnt=0, k+1. Releasing the last stage also moves to RUN and sets ready_o=1. With STAGES=1, STABLE goes directly to RUN.
  - RUN: hold all outputs high.
- lock_s=0 in RELEASE or RUN: next edge sets all rst_n_o=0 and ready_o=0, state WAIT_LOCK, loss_cnt_o+1 (saturates at 255).
- Lock drop takes priority over a same-cycle stage release or count completion.
- Released outputs stay high until a lock drop or rst_n_i; they never toggle individually.
- Counter width: $clog2(max(LOCK_CYCLES, STAGE_GAP)); counter compares are exact equality.
- lock_i pulses shorter than one clk_i period may go undetected. This is accepted.

## Timing
- All outputs are registered. No combinational path from lock_i.
- lock_i stable high from edge N:
  - state STABLE at edge N+SYNC_STAGES.
  - rst_n_o[0] rises at edge N+SYNC_STAGES+LOCK_CYCLES.
  - rst_n_o[k] rises k·STAGE_GAP edges later.
  - ready_o rises on the same edge as rst_n_o[STAGES-1].
- lock_i low from edge M in RELEASE or RUN: all resets low and loss_cnt_o incremented at edge M+SYNC_STAGES.
- Re-lock after a loss restarts the full LOCK_CYCLES qualification.
- rst_n_i deassertion: the first possible STABLE entry is SYNC_STAGES edges after lock_i is sampled high.

## Structure
- Shared clock/reset package holds the state enum rst_seq_state_t {WAIT_LOCK, STABLE, RELEASE, RUN}, 2-bit.
- Parameter range checks are elaboration-time assertions in the module.
- Sub-module cdc_sync (parameter STAGES, async active-low reset, 1-bit) implements the lock synchronizer and is reusable elsewhere.

## Test plan
Settings: SYNC_STAGES=2, LOCK_CYCLES=8, STAGES=3, STAGE_GAP=4.
- Clean lock: lock_i high before edge 10 → rst_n_o[0] at edge 20, rst_n_o[1] at 24, rst_n_o[2] and ready_o at 28; loss_cnt_o=0.
- Unstable lock: lock_i high 5 cycles, low 1, high again → no release during the first 5-cycle window; after the final rise, release follows the clean-lock timing; loss_cnt_o=0.
- Loss in RUN: drop lock_i before edge 40 after ready → all rst_n_o=0, ready_o=0, loss_cnt_o=1 at edge 42; re-lock repeats the 8+2 cycle qualification.
- Loss mid-RELEASE: drop lock_i so lock_s=0 on the cycle rst_n_o[1] would rise → rst_n_o[1] stays low, rst_n_o[0] drops, loss_cnt_o=1.
- Saturation: 260 loss events → loss_cnt_o holds 255.
- Async reset mid-RELEASE: pulse rst_n_i low between edges → outputs low immediately (before the next edge), loss_cnt_o=0, sequence restarts from WAIT_LOCK.
